// File: rtl/decoder_pkg.sv
// Shared encodings and the decoded-instruction bundle for the RV32I OP-IMM decoder.
package decoder_pkg;

  localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
  localparam logic [2:0] F3_ADDI       = 3'b000;
  localparam logic [2:0] F3_SLLI       = 3'b001;
  localparam logic [2:0] F3_XORI       = 3'b100;
  localparam logic [2:0] F3_SR         = 3'b101;
  localparam logic [2:0] F3_ORI        = 3'b110;
  localparam logic [2:0] F3_ANDI       = 3'b111;
  localparam logic [6:0] FUNCT7_SRLI   = 7'b0000000;

  typedef struct packed {
    logic        addi_en;
    logic        andi_en;
    logic        ori_en;
    logic        slli_en;
    logic        xori_en;
    logic        srli_en;
    logic        srai_en;
    logic [4:0]  rs1;
    logic [4:0]  rd;
    logic        rd_en;
    logic        wr_en;
    logic [11:0] imm;
  } dec_out_t;

endpackage

// File: rtl/decoder_comb.sv
// Combinational OP-IMM decode: one-hot op enable plus field extraction.
// Anything not decodable collapses to an all-zero bundle.
module decoder_comb
  import decoder_pkg::*;
(
  input  logic [31:0] instruction,
  output dec_out_t    dec
);

  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       vld;

  assign funct3 = instruction[14:12];
  assign funct7 = instruction[31:25];

  always_comb begin
    dec = '0;
    vld = 1'b0;
    if (instruction[6:0] == OPCODE_OP_IMM) begin
      vld = 1'b1;
      unique case (funct3)
        F3_ADDI: dec.addi_en = 1'b1;
        F3_SLLI: dec.slli_en = 1'b1;
        F3_XORI: dec.xori_en = 1'b1;
        F3_SR: begin
          if (funct7 == FUNCT7_SRLI) dec.srli_en = 1'b1;
          else                       dec.srai_en = 1'b1;
        end
        F3_ORI:  dec.ori_en  = 1'b1;
        F3_ANDI: dec.andi_en = 1'b1;
        default: vld = 1'b0; // SLTI/SLTIU not supported here
      endcase
    end
    if (vld) begin
      dec.rs1   = instruction[19:15];
      dec.rd    = instruction[11:7];
      dec.imm   = instruction[31:20];
      dec.rd_en = 1'b1;
      dec.wr_en = 1'b1;
    end
  end

endmodule

// File: rtl/decoder.sv
// Registered RV32I OP-IMM decoder; one cycle latency, async active-high clear.
module decoder
  import decoder_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instruction,
  output logic        addi_en,
  output logic        andi_en,
  output logic        ori_en,
  output logic        slli_en,
  output logic        xori_en,
  output logic        srli_en,
  output logic        srai_en,
  output logic [4:0]  rs1,
  output logic [4:0]  rd,
  output logic        rd_en,
  output logic        wr_en,
  output logic [11:0] imm
);

  dec_out_t dec_d, dec_q;

  decoder_comb u_comb (
    .instruction (instruction),
    .dec         (dec_d)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) dec_q <= '0;
    else       dec_q <= dec_d;
  end

  assign addi_en = dec_q.addi_en;
  assign andi_en = dec_q.andi_en;
  assign ori_en  = dec_q.ori_en;
  assign slli_en = dec_q.slli_en;
  assign xori_en = dec_q.xori_en;
  assign srli_en = dec_q.srli_en;
  assign srai_en = dec_q.srai_en;
  assign rs1     = dec_q.rs1;
  assign rd      = dec_q.rd;
  assign rd_en   = dec_q.rd_en;
  assign wr_en   = dec_q.wr_en;
  assign imm     = dec_q.imm;

endmodule

// File: tb/tb_decoder.sv
// Directed vector bench for the OP-IMM decoder with hand-computed expectations.
module tb_decoder;

  localparam logic [6:0] OP = 7'b0010011;
  // enable order: addi, andi, ori, slli, xori, srli, srai
  localparam logic [6:0] E_NONE = 7'b0000000;
  localparam logic [6:0] E_ADDI = 7'b1000000;
  localparam logic [6:0] E_ANDI = 7'b0100000;
  localparam logic [6:0] E_ORI  = 7'b0010000;
  localparam logic [6:0] E_SLLI = 7'b0001000;
  localparam logic [6:0] E_XORI = 7'b0000100;
  localparam logic [6:0] E_SRLI = 7'b0000010;
  localparam logic [6:0] E_SRAI = 7'b0000001;

  typedef struct packed {
    logic [6:0]  en;
    logic [4:0]  rs1;
    logic [4:0]  rd;
    logic        rd_en;
    logic        wr_en;
    logic [11:0] imm;
  } obs_t;

  typedef struct {
    string       name;
    logic [31:0] instr;
    obs_t        exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instruction;
  logic        addi_en, andi_en, ori_en, slli_en, xori_en, srli_en, srai_en;
  logic [4:0]  rs1, rd;
  logic        rd_en, wr_en;
  logic [11:0] imm;

  int errors = 0;
  int checks = 0;

  decoder dut (
    .clk         (clk),
    .reset       (reset),
    .instruction (instruction),
    .addi_en     (addi_en),
    .andi_en     (andi_en),
    .ori_en      (ori_en),
    .slli_en     (slli_en),
    .xori_en     (xori_en),
    .srli_en     (srli_en),
    .srai_en     (srai_en),
    .rs1         (rs1),
    .rd          (rd),
    .rd_en       (rd_en),
    .wr_en       (wr_en),
    .imm         (imm)
  );

  always #5 clk = ~clk;

  function automatic obs_t observe();
    obs_t o;
    o.en    = {addi_en, andi_en, ori_en, slli_en, xori_en, srli_en, srai_en};
    o.rs1   = rs1;
    o.rd    = rd;
    o.rd_en = rd_en;
    o.wr_en = wr_en;
    o.imm   = imm;
    return o;
  endfunction

  function automatic obs_t mk(logic [6:0] en, logic [4:0] r1, logic [4:0] rdi, logic [11:0] im);
    obs_t o;
    o.en    = en;
    o.rs1   = r1;
    o.rd    = rdi;
    o.rd_en = (en != E_NONE);
    o.wr_en = (en != E_NONE);
    o.imm   = im;
    return o;
  endfunction

  task automatic check(string name, obs_t exp);
    obs_t act;
    act = observe();
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got en=%b rs1=%0d rd=%0d rd_en=%b wr_en=%b imm=%h, expected en=%b rs1=%0d rd=%0d rd_en=%b wr_en=%b imm=%h",
               name, act.en, act.rs1, act.rd, act.rd_en, act.wr_en, act.imm,
               exp.en, exp.rs1, exp.rd, exp.rd_en, exp.wr_en, exp.imm);
    end
  endtask

  // drive on the falling edge, sample just after the next rising edge
  task automatic step(logic [31:0] instr);
    @(negedge clk);
    instruction = instr;
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[$];

  initial begin
    vecs.push_back('{"addi",     {7'b0011000, 5'b00100, 5'd7,  3'b000, 5'd9,  OP}, mk(E_ADDI, 5'd7,  5'd9,  12'h304)});
    vecs.push_back('{"srli",     {7'b0000000, 5'b00000, 5'd7,  3'b101, 5'd9,  OP}, mk(E_SRLI, 5'd7,  5'd9,  12'h000)});
    vecs.push_back('{"srai_f7_1",{7'b0000001, 5'b00000, 5'd5,  3'b101, 5'd13, OP}, mk(E_SRAI, 5'd5,  5'd13, 12'h020)});
    vecs.push_back('{"slli",     {7'b0100010, 5'b01101, 5'd5,  3'b001, 5'd19, OP}, mk(E_SLLI, 5'd5,  5'd19, 12'h44D)});
    vecs.push_back('{"ori",      {7'b0100000, 5'b01010, 5'd5,  3'b110, 5'd13, OP}, mk(E_ORI,  5'd5,  5'd13, 12'h40A)});
    vecs.push_back('{"andi",     {7'b1001000, 5'b00100, 5'd7,  3'b111, 5'd9,  OP}, mk(E_ANDI, 5'd7,  5'd9,  12'h904)});
    vecs.push_back('{"xori",     {7'b0000011, 5'b00100, 5'd7,  3'b100, 5'd9,  OP}, mk(E_XORI, 5'd7,  5'd9,  12'h064)});
    vecs.push_back('{"bad_op",   32'h12345678,                                     mk(E_NONE, 5'd0,  5'd0,  12'h000)});
    vecs.push_back('{"srai_std", {7'b0100000, 5'd3,     5'd1,  3'b101, 5'd2,  OP}, mk(E_SRAI, 5'd1,  5'd2,  12'h403)});
    vecs.push_back('{"slti",     {7'b0011000, 5'b00100, 5'd7,  3'b010, 5'd9,  OP}, mk(E_NONE, 5'd0,  5'd0,  12'h000)});
    vecs.push_back('{"addi_rd0", {7'b0000000, 5'd5,     5'd3,  3'b000, 5'd0,  OP}, mk(E_ADDI, 5'd3,  5'd0,  12'h005)});
    vecs.push_back('{"sltiu",    {7'b1111111, 5'b11111, 5'd31, 3'b011, 5'd31, OP}, mk(E_NONE, 5'd0,  5'd0,  12'h000)});
    vecs.push_back('{"addi_max", {12'hFFF,              5'd31, 3'b000, 5'd31, OP}, mk(E_ADDI, 5'd31, 5'd31, 12'hFFF)});
    vecs.push_back('{"op_bit0",  {7'b0011000, 5'b00100, 5'd7,  3'b000, 5'd9,  7'b0010010}, mk(E_NONE, 5'd0, 5'd0, 12'h000)});
    vecs.push_back('{"andi2",    {7'b0000000, 5'b00001, 5'd30, 3'b111, 5'd17, OP}, mk(E_ANDI, 5'd30, 5'd17, 12'h001)});

    // reset is asynchronous: outputs must be zero before any clock edge
    reset = 1'b1;
    instruction = 32'h0;
    #1;
    check("reset_async", mk(E_NONE, 5'd0, 5'd0, 12'h000));

    @(negedge clk);
    reset = 1'b0;
    step(32'h0);
    check("post_reset_zero", mk(E_NONE, 5'd0, 5'd0, 12'h000));

    // back-to-back vectors, one per cycle
    foreach (vecs[i]) begin
      step(vecs[i].instr);
      check(vecs[i].name, vecs[i].exp);
      checks++;
      if ($countones(observe().en) > 1) begin
        errors++;
        $display("FAIL onehot_%s: got en=%b, expected at most one bit set", vecs[i].name, observe().en);
      end
    end

    // mid-stream reset between edges clears outputs without a clock edge
    step(vecs[0].instr);
    check("pre_midreset", vecs[0].exp);
    @(negedge clk);
    instruction = vecs[3].instr;
    reset = 1'b1;
    #1;
    check("midreset_async", mk(E_NONE, 5'd0, 5'd0, 12'h000));
    @(posedge clk);
    #1;
    check("reset_held_edge", mk(E_NONE, 5'd0, 5'd0, 12'h000));
    // instruction present at deassertion is decoded at the next edge
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("deassert_no_edge", mk(E_NONE, 5'd0, 5'd0, 12'h000));
    @(posedge clk);
    #1;
    check("first_after_reset", vecs[3].exp);

    step(vecs[4].instr);
    check("resume_ori", vecs[4].exp);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
